// File: rtl/registers_array_pkg.sv
// Shared widths and types for the CPU general-purpose register file.
// Default geometry: eight 32-bit registers.
package registers_array_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/registers_array.sv
// Register file: one synchronous write port, two combinational read ports.
// Reads see the word being written in the same cycle (write-first bypass).
module registers_array #(
    parameter int DATA_W = registers_array_pkg::DATA_W,
    parameter int ADDR_W = registers_array_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    import registers_array_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;

    for (genvar i = 0; i < NREGS; i++) begin : g_entry
        always_comb begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Bypass is suppressed during reset so outputs read zero at once.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0]            addr,
        input logic [NREGS-1:0][DATA_W-1:0] regs,
        input logic                         in_rst,
        input logic                         we,
        input logic [ADDR_W-1:0]            waddr,
        input logic [DATA_W-1:0]            wdata
    );
        logic [DATA_W-1:0] val;
        val = regs[addr];
        if (in_rst) begin
            val = '0;
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end
        return val;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1, regs_q, rst, wr_en, wr_addr, wr_data);
        rd_data2 = read_port(rd_addr2, regs_q, rst, wr_en, wr_addr, wr_data);
    end

endmodule

// File: tb/tb_registers_array.sv
// Directed plus random bench for registers_array against an array model.
// Expected read values come from the model and the current write inputs.
module tb_registers_array;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [2:0]  wr_addr;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;

    logic [31:0] model [8];
    int errors;
    int checks;

    registers_array dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_addr  (wr_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        if (rst) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    task automatic chk_ports(input string tag);
        #1;
        chk({tag, "_p1"}, rd_data1, exp_rd(rd_addr1));
        chk({tag, "_p2"}, rd_data2, exp_rd(rd_addr2));
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (!rst && wr_en) model[wr_addr] = wr_data;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 32'h0;
        wr_addr  = 3'd0;
        rd_addr1 = 3'd0;
        rd_addr2 = 3'd0;
        clear_model();

        // Reset: every index reads zero on both ports.
        #2;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            rd_addr2 = 3'(7 - i);
            #1;
            chk("reset_p1", rd_data1, 32'h0);
            chk("reset_p2", rd_data2, 32'h0);
        end
        // Writes are ignored while reset is held.
        wr_en   = 1'b1;
        wr_data = 32'h5555AAAA;
        wr_addr = 3'd1;
        rd_addr1 = 3'd1;
        #1;
        chk("rst_nobypass", rd_data1, 32'h0);
        clk_edge();
        wr_en = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst_nowrite", rd_data1, 32'h0);

        // r0 is writable.
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 32'hACEDCAFE;
        clk_edge();
        wr_en    = 1'b0;
        rd_addr1 = 3'd0;
        #1;
        chk("r0", rd_data1, 32'hACEDCAFE);

        // Isolation.
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 32'hDEADBEEF;
        clk_edge();
        wr_en    = 1'b0;
        rd_addr1 = 3'd2;
        #1;
        chk("iso_r2", rd_data1, 32'h0);
        rd_addr1 = 3'd3;
        #1;
        chk("iso_r3", rd_data1, 32'hDEADBEEF);
        rd_addr1 = 3'd0;
        #1;
        chk("iso_r0", rd_data1, 32'hACEDCAFE);

        // Top index and dual read.
        wr_en   = 1'b1;
        wr_addr = 3'd7;
        wr_data = 32'hDEADBEEF;
        clk_edge();
        wr_en    = 1'b0;
        rd_addr1 = 3'd7;
        rd_addr2 = 3'd3;
        #1;
        chk("top_p1", rd_data1, 32'hDEADBEEF);
        chk("top_p2", rd_data2, 32'hDEADBEEF);
        rd_addr1 = 3'd0;
        rd_addr2 = 3'd0;
        #1;
        chk("same_p1", rd_data1, 32'hACEDCAFE);
        chk("same_p2", rd_data2, 32'hACEDCAFE);

        // Bypass, then wr_en=0 holds.
        wr_en    = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 32'h12345678;
        rd_addr1 = 3'd4;
        rd_addr2 = 3'd5;
        #1;
        chk("bypass_p2", rd_data2, 32'h12345678);
        chk("bypass_p1", rd_data1, 32'h0);
        clk_edge();
        wr_en   = 1'b0;
        wr_data = 32'hFFFFFFFF;
        clk_edge();
        #1;
        chk("hold_r5", rd_data2, 32'h12345678);

        // Async reset mid-operation discards the pending write.
        #2;
        wr_en    = 1'b1;
        wr_addr  = 3'd6;
        wr_data  = 32'hCAFEF00D;
        rd_addr1 = 3'd6;
        rd_addr2 = 3'd0;
        rst      = 1'b1;
        clear_model();
        #1;
        chk("midrst_p1", rd_data1, 32'h0);
        chk("midrst_p2", rd_data2, 32'h0);
        clk_edge();
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            rd_addr2 = 3'(i);
            #1;
            chk("postrst_p1", rd_data1, 32'h0);
            chk("postrst_p2", rd_data2, 32'h0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = $urandom;
            rd_addr1 = 3'($urandom_range(0, 7));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr
                                                   : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                clear_model();
            end
            chk_ports("rand");
            clk_edge();
            rst = 1'b0;
        end

        // Final sweep of the whole file with no write pending.
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            rd_addr2 = 3'(7 - i);
            chk_ports("sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
